// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin result-bus arbiter with a small queue per producer channel
// Define CDB_FLUSH_EN to add flush_in, which discards every pending result.
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          req_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    req_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   req_data,
  output logic [NUM_SRC-1:0]          req_ready,
`ifdef CDB_FLUSH_EN
  input  logic                        flush_in,
`endif
  output logic                        valid_out,
  output logic [TAG_W-1:0]            tag_out,
  output logic [DATA_W-1:0]           data_out,
  output logic [$clog2(NUM_SRC)-1:0]  src_out
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]  tag_mem_q  [NUM_SRC][DEPTH];
  logic [DATA_W-1:0] data_mem_q [NUM_SRC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_SRC];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_SRC];
  logic [CNT_W-1:0]  cnt_q    [NUM_SRC];
  logic [CNT_W-1:0]  cnt_d    [NUM_SRC];
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;
  logic [SRC_W-1:0]  src_q;

  logic [NUM_SRC-1:0] push, pop, nonempty;
  logic               gnt_valid;
  logic [SRC_W-1:0]   gnt_idx;

  // Ready comes from the registered count only, so a full channel stays closed even when granted.
  always_comb begin
    req_ready = '0;
    nonempty  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      req_ready[i] = (cnt_q[i] < CNT_W'(DEPTH));
      nonempty[i]  = (cnt_q[i] != '0);
    end
    push = req_valid & req_ready;
  end

  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!gnt_valid && nonempty[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'(idx);
      end
    end
    pop      = gnt_valid ? (NUM_SRC'(1) << gnt_idx) : '0;
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) rr_ptr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
    end
  end

  // Queue storage needs no reset: occupancy and pointers decide what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i]]  <= req_tag[i*TAG_W +: TAG_W];
        data_mem_q[i][wr_ptr_q[i]] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      data_q   <= '0;
      src_q    <= '0;
    end
`ifdef CDB_FLUSH_EN
    else if (flush_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i]    <= '0;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      valid_q <= 1'b0;
    end
`endif
    else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cnt_q[i]    <= cnt_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= gnt_valid;
      if (gnt_valid) begin
        tag_q  <= tag_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
        data_q <= data_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
        src_q  <= gnt_idx;
      end
    end
  end

  assign valid_out = valid_q;
  assign tag_out   = tag_q;
  assign data_out  = data_q;
  assign src_out   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and scoreboard checks for cdb_arbiter
module tb_cdb_arbiter;
  localparam int NUM_SRC = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_SRC-1:0]         req_valid;
  logic [NUM_SRC*TAG_W-1:0]   req_tag;
  logic [NUM_SRC*DATA_W-1:0]  req_data;
  logic [NUM_SRC-1:0]         req_ready;
`ifdef CDB_FLUSH_EN
  logic                       flush_in;
`endif
  logic                       valid_out;
  logic [TAG_W-1:0]           tag_out;
  logic [DATA_W-1:0]          data_out;
  logic [1:0]                 src_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TAG_W+DATA_W-1:0] sb [NUM_SRC][$];

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef CDB_FLUSH_EN
    .flush_in  (flush_in),
`endif
    .valid_out (valid_out),
    .tag_out   (tag_out),
    .data_out  (data_out),
    .src_out   (src_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
`ifdef CDB_FLUSH_EN
    flush_in  = 1'b0;
`endif
  endtask

  task automatic set_ch(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    req_valid[ch]                 = 1'b1;
    req_tag[ch*TAG_W +: TAG_W]    = t;
    req_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) set_ch(i, 5'h15, 32'h1234_5678);
    tick();
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    n_checks++; if (tag_out !== 5'h00) begin n_fail++; $display("FAIL reset_tag: got %h want 00", tag_out); end
    n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out); end
    n_checks++; if (src_out !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", src_out); end
    n_checks++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b want 1111", req_ready); end
    rst_n = 1'b1;
    clear_inputs();
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_push_dropped: got %b want 0", valid_out); end
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0", valid_out); end
  endtask

  task automatic test_single();
    do_reset();
    set_ch(2, 5'h0A, 32'hDEADBEEF);
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", valid_out); end
    clear_inputs();
    tick();
    n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", valid_out); end
    n_checks++; if (tag_out !== 5'h0A) begin n_fail++; $display("FAIL single_tag: got %h want 0a", tag_out); end
    n_checks++; if (data_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", data_out); end
    n_checks++; if (src_out !== 2'd2) begin n_fail++; $display("FAIL single_src: got %0d want 2", src_out); end
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", valid_out); end
    n_checks++; if (tag_out !== 5'h0A || src_out !== 2'd2) begin n_fail++; $display("FAIL single_hold: got tag %h src %0d want 0a 2", tag_out, src_out); end
  endtask

  task automatic test_contention();
    logic [TAG_W-1:0] t;
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      t = 5'h10 + 5'(i);
      set_ch(i, t, 32'hC0DE_0000 + 32'(i));
    end
    tick();
    clear_inputs();
    for (int i = 0; i < NUM_SRC; i++) begin
      tick();
      t = 5'h10 + 5'(i);
      n_checks++;
      if (valid_out !== 1'b1 || src_out !== 2'(i) || tag_out !== t || data_out !== 32'hC0DE_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL contention_%0d: got v=%b src=%0d tag=%h data=%h want v=1 src=%0d tag=%h data=%h",
                 i, valid_out, src_out, tag_out, data_out, i, t, 32'hC0DE_0000 + 32'(i));
      end
    end
    tick();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL contention_drain: got %b want 0", valid_out); end
  endtask

  task automatic test_rr_wrap();
    do_reset();
    set_ch(1, 5'h01, 32'h0000_0111);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (valid_out !== 1'b1 || src_out !== 2'd1) begin n_fail++; $display("FAIL wrap_first: got v=%b src=%0d want v=1 src=1", valid_out, src_out); end
    set_ch(0, 5'h02, 32'h0000_0222);
    set_ch(3, 5'h03, 32'h0000_0333);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (valid_out !== 1'b1 || src_out !== 2'd3 || tag_out !== 5'h03) begin n_fail++; $display("FAIL wrap_src3: got v=%b src=%0d tag=%h want v=1 src=3 tag=03", valid_out, src_out, tag_out); end
    tick();
    n_checks++; if (valid_out !== 1'b1 || src_out !== 2'd0 || tag_out !== 5'h02) begin n_fail++; $display("FAIL wrap_src0: got v=%b src=%0d tag=%h want v=1 src=0 tag=02", valid_out, src_out, tag_out); end
  endtask

  task automatic test_backpressure();
    int a_idx, b_idx, got_a, got_b, got_other;
    logic [NUM_SRC-1:0] acc;
    logic [DATA_W-1:0] a_seen [4];
    logic [DATA_W-1:0] b_seen [3];
    do_reset();
    a_idx = 0; b_idx = 0; got_a = 0; got_b = 0; got_other = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      clear_inputs();
      if (a_idx < 4) set_ch(0, 5'(a_idx), 32'hA0A0_0000 + 32'(a_idx));
      if (b_idx < 3) set_ch(1, 5'h10 + 5'(b_idx), 32'hB1B1_0000 + 32'(b_idx));
      acc = req_valid & req_ready;
      tick();
      if (acc[0]) a_idx++;
      if (acc[1]) b_idx++;
      if (cyc == 1) begin
        n_checks++; if (req_ready !== 4'b1101) begin n_fail++; $display("FAIL bp_ready_full: got %b want 1101", req_ready); end
      end
      if (cyc == 2) begin
        n_checks++; if (req_ready !== 4'b1110) begin n_fail++; $display("FAIL bp_ready_after_grant: got %b want 1110", req_ready); end
        n_checks++; if (b_idx !== 2) begin n_fail++; $display("FAIL bp_third_held: got %0d accepted want 2", b_idx); end
      end
      if (valid_out === 1'b1) begin
        if (src_out === 2'd0) begin if (got_a < 4) a_seen[got_a] = data_out; got_a++; end
        else if (src_out === 2'd1) begin if (got_b < 3) b_seen[got_b] = data_out; got_b++; end
        else got_other++;
      end
    end
    clear_inputs();
    n_checks++; if (got_a !== 4 || got_b !== 3 || got_other !== 0) begin n_fail++; $display("FAIL bp_counts: got a=%0d b=%0d other=%0d want 4 3 0", got_a, got_b, got_other); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (got_b > k && b_seen[k] !== 32'hB1B1_0000 + 32'(k)) begin n_fail++; $display("FAIL bp_order_b%0d: got %h want %h", k, b_seen[k], 32'hB1B1_0000 + 32'(k)); end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (got_a > k && a_seen[k] !== 32'hA0A0_0000 + 32'(k)) begin n_fail++; $display("FAIL bp_order_a%0d: got %h want %h", k, a_seen[k], 32'hA0A0_0000 + 32'(k)); end
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    do_reset();
    set_ch(1, 5'h1E, 32'h1111_1111);
    set_ch(2, 5'h1D, 32'h2222_2222);
    set_ch(3, 5'h1C, 32'h3333_3333);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (valid_out !== 1'b1 || src_out !== 2'd1 || tag_out !== 5'h1E) begin n_fail++; $display("FAIL mid_pre: got v=%b src=%0d tag=%h want 1 1 1e", valid_out, src_out, tag_out); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (valid_out !== 1'b0 || tag_out !== 5'h00 || data_out !== 32'h0 || src_out !== 2'd0) begin n_fail++; $display("FAIL mid_reset_out: got v=%b tag=%h data=%h src=%0d want all 0", valid_out, tag_out, data_out, src_out); end
    n_checks++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1111", req_ready); end
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (valid_out !== 1'b0) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d broadcasts want 0", stale); end
    set_ch(0, 5'h07, 32'h7777_7777);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (valid_out !== 1'b1 || src_out !== 2'd0 || tag_out !== 5'h07) begin n_fail++; $display("FAIL mid_first_after: got v=%b src=%0d tag=%h want 1 0 07", valid_out, src_out, tag_out); end
  endtask

`ifdef CDB_FLUSH_EN
  task automatic test_flush();
    int stray;
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) set_ch(i, 5'(i + 1), 32'hF000_0000 + 32'(i));
    tick();
    clear_inputs();
    set_ch(0, 5'h05, 32'hF000_0005);
    tick();
    n_checks++; if (valid_out !== 1'b1 || src_out !== 2'd0 || tag_out !== 5'h01) begin n_fail++; $display("FAIL flush_pre: got v=%b src=%0d tag=%h want 1 0 01", valid_out, src_out, tag_out); end
    clear_inputs();
    flush_in = 1'b1;
    set_ch(3, 5'h1F, 32'hFFFF_FFFF);
    tick();
    clear_inputs();
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", valid_out); end
    n_checks++; if (tag_out !== 5'h01 || src_out !== 2'd0) begin n_fail++; $display("FAIL flush_hold: got tag=%h src=%0d want 01 0", tag_out, src_out); end
    n_checks++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL flush_ready: got %b want 1111", req_ready); end
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (valid_out !== 1'b0) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL flush_empty: got %0d broadcasts want 0", stray); end
    set_ch(2, 5'h12, 32'h0000_0012);
    tick();
    clear_inputs();
    tick();
    n_checks++; if (valid_out !== 1'b1 || src_out !== 2'd2 || tag_out !== 5'h12) begin n_fail++; $display("FAIL flush_after: got v=%b src=%0d tag=%h want 1 2 12", valid_out, src_out, tag_out); end
  endtask
`endif

  task automatic test_soak();
    logic [NUM_SRC-1:0] acc;
    logic [TAG_W+DATA_W-1:0] exp_e;
    logic [TAG_W+DATA_W-1:0] pend [NUM_SRC];
    int wait_cnt [NUM_SRC];
    int max_wait, s;
    logic any_pending;
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) begin sb[i].delete(); wait_cnt[i] = 0; end
    max_wait = 0;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      clear_inputs();
      if (cyc < 10000) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if ($urandom_range(0, 99) < 45) set_ch(i, 5'($urandom), $urandom);
        end
      end
      acc = req_valid & req_ready;
      for (int i = 0; i < NUM_SRC; i++) pend[i] = {req_tag[i*TAG_W +: TAG_W], req_data[i*DATA_W +: DATA_W]};
      tick();
      n_checks++;
      if (valid_out === 1'b1) begin
        s = int'(src_out);
        if (sb[s].size() == 0) begin
          n_fail++; $display("FAIL soak_spurious: cycle %0d src %0d broadcast with nothing queued", cyc, s);
        end else begin
          exp_e = sb[s].pop_front();
          if ({tag_out, data_out} !== exp_e) begin
            n_fail++; $display("FAIL soak_data: cycle %0d src %0d got %h want %h", cyc, s, {tag_out, data_out}, exp_e);
          end
        end
        for (int c = 0; c < NUM_SRC; c++) begin
          if (c == s || sb[c].size() == 0) wait_cnt[c] = 0;
          else wait_cnt[c]++;
          if (wait_cnt[c] > max_wait) max_wait = wait_cnt[c];
        end
      end else begin
        any_pending = 1'b0;
        for (int c = 0; c < NUM_SRC; c++) if (sb[c].size() != 0) any_pending = 1'b1;
        if (any_pending) begin n_fail++; $display("FAIL soak_idle: cycle %0d no broadcast while entries pending", cyc); end
      end
      for (int i = 0; i < NUM_SRC; i++) if (acc[i]) sb[i].push_back(pend[i]);
    end
    n_checks++; if (max_wait > NUM_SRC * DEPTH) begin n_fail++; $display("FAIL soak_starve: got wait %0d want <= %0d", max_wait, NUM_SRC * DEPTH); end
    for (int i = 0; i < NUM_SRC; i++) begin
      n_checks++; if (sb[i].size() != 0) begin n_fail++; $display("FAIL soak_lost_ch%0d: got %0d undelivered want 0", i, sb[i].size()); end
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_rr_wrap();
    test_backpressure();
    test_reset_midstream();
`ifdef CDB_FLUSH_EN
    test_flush();
`endif
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of producer channels (legal 2..8).
REQ-002 Parameter TAG_W, default 5, tag width.
REQ-003 Parameter DATA_W, default 32, result data width.
REQ-004 Parameter DEPTH, default 2, per-channel queue entries (power of two, at least 2).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  NUM_SRC  per-channel result-offer strobe.
REQ-008 req_tag  input  NUM_SRC*TAG_W  packed per-channel tags; channel i occupies bits [i*TAG_W +: TAG_W].
REQ-009 req_data  input  NUM_SRC*DATA_W  packed per-channel data; same packing as req_tag.
REQ-010 req_ready  output  NUM_SRC  per-channel queue-not-full indication.
REQ-011 flush_in  input  1  discard all pending results; present only with CDB_FLUSH_EN.
REQ-012 valid_out  output  1  broadcast valid.
REQ-013 tag_out  output  TAG_W  broadcast tag.
REQ-014 data_out  output  DATA_W  broadcast data.
REQ-015 src_out  output  clog2(NUM_SRC)  index of the channel that produced the current broadcast.

Function
REQ-016 Each channel SHALL own a FIFO of DEPTH {tag, data} entries with read/write pointers that wrap modulo DEPTH and an occupancy count of width clog2(DEPTH)+1.
REQ-017 req_ready[i] SHALL equal "channel i count < DEPTH"; it is combinational from registered state only and never depends on req_valid.
REQ-018 Channel i SHALL push an entry at an edge where req_valid[i] and req_ready[i] are both 1; req_valid while not ready SHALL be ignored, with no state change.
REQ-019 Each cycle a round-robin arbiter SHALL grant exactly one non-empty channel, searching upward from the pointer rr_ptr and wrapping from NUM_SRC-1 to 0.
REQ-020 On a grant to channel g, the FIFO head of g SHALL be popped, registered into tag_out/data_out, src_out SHALL become g, valid_out SHALL become 1 at the same edge, and rr_ptr SHALL become (g+1) mod NUM_SRC.
REQ-021 If no channel is non-empty, valid_out SHALL become 0 at the edge, tag_out/data_out/src_out SHALL hold, and rr_ptr SHALL hold.
REQ-022 Latency: an entry pushed into an empty channel at edge k, with no competing channel, SHALL be broadcast (valid_out=1) after edge k+1; there is no same-cycle bypass.
REQ-023 A push and a pop on the same channel in the same cycle SHALL both take effect: count unchanged, both pointers advance.
REQ-024 A full channel SHALL NOT accept a push even if it is granted that cycle; req_ready deasserts for the full cycle.
REQ-025 Each valid_out pulse SHALL correspond to exactly one accepted entry; no entry is lost or duplicated, and per-channel order is preserved.
REQ-026 With all NUM_SRC channels continuously non-empty, grants SHALL rotate 0,1,...,NUM_SRC-1 with no channel granted twice before every other non-empty channel has been granted once.

Reset
REQ-027 When rst_n=0 at a rising edge, all counts, pointers and rr_ptr SHALL clear to 0, valid_out to 0, tag_out to 0, data_out to 0 and src_out to 0; pushes that cycle SHALL be dropped.
REQ-028 Reset asserted mid-stream SHALL discard all queued entries; the first post-reset broadcast SHALL come from an entry accepted after rst_n returns high.
REQ-029 While rst_n=0, req_ready SHALL read all-ones, since counts are 0 after the first reset edge.

Configuration
REQ-030 Macro CDB_FLUSH_EN: when defined, the flush_in port SHALL exist, and flush_in=1 at an edge SHALL zero all counts and pointers, force valid_out to 0, drop that cycle's pushes and grant, and hold rr_ptr, tag_out, data_out and src_out.
REQ-031 When CDB_FLUSH_EN is undefined, the flush_in port and all flush logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-032 Single channel: reset, then channel 2 offers tag=5'h0A, data=32'hDEADBEEF at edge 3 -> valid_out=1, tag_out=0A, data_out=DEADBEEF, src_out=2 after edge 4 only.
REQ-033 Contention: all 4 channels offer one entry each in the same cycle, with rr_ptr=0 -> four consecutive broadcasts with src_out 0,1,2,3, then valid_out=0.
REQ-034 Backpressure: DEPTH=2, channel 1 offers 3 back-to-back entries while channel 0 is kept non-empty -> req_ready[1]=0 after 2 pushes, the third entry is held by the source, and all 3 entries are broadcast in order.
REQ-035 Reset mid-stream: 3 entries queued, rst_n=0 for one edge -> valid_out=0, req_ready all-ones, and no stale tag is broadcast afterwards.
REQ-036 Flush (CDB_FLUSH_EN): 4 entries queued, flush_in=1 for one cycle with a simultaneous push on channel 3 -> valid_out=0 the next cycle, all channels empty, and the channel-3 entry is dropped.
REQ-037 Random soak: 10k cycles of random req_valid with a scoreboard -> every accepted {tag, data} is broadcast exactly once in per-channel order, and no channel waits more than NUM_SRC*DEPTH grants.
